// File: rtl/bool_eval_pkg.sv
// bool_eval_pkg: shared constants and sizing helpers for the Boolean-function
// evaluator.
//   DEPTH_OF(n)  - truth-table depth for n input variables (1<<n)
//   CFG_SEL_W(n) - width of a function-select field for n functions (min 1)
//   F1_TT, F2_TT - legacy SOP functions expressed as truth tables; the first
//                  listed variable is the MSB of the table index.
package bool_eval_pkg;

   localparam logic [15:0] F1_TT = 16'h35A5;
   localparam logic [15:0] F2_TT = 16'hEEE2;

   function automatic int DEPTH_OF(input int n);
      return 1 << n;
   endfunction

   function automatic int CFG_SEL_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bool_eval_stage.sv
// bool_eval_stage: one valid/ready register slice.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready = ~out_valid | out_ready
//   in_data  [W]          data captured on an upstream handshake
//   out_valid/out_ready   downstream handshake
//   out_data [W]          registered data, held while stalled
module bool_eval_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // The slice may take a new entry whenever it is empty or its current
   // entry leaves in the same cycle.
   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) out_data <= in_data;
      end
   end

endmodule

// File: rtl/bool_func_eval.sv
// bool_func_eval: two-stage pipelined evaluator of N_FUNC Boolean functions of
// N_IN variables, each held as a runtime-writable truth table.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    sample input handshake (in_ready low during reset)
//   in_vars   [N_IN]     variable vector, MSB is the first variable
//   out_valid/out_ready  result handshake
//   out_f     [N_FUNC]   out_f[f] = table f indexed by the sample
//   out_vars  [N_IN]     echo of the evaluated sample
//   cfg_we/cfg_sel/cfg_table  truth-table write port (out-of-range sel ignored)
//   eval_cnt  [CNT_W]    saturating count of output handshakes
module bool_func_eval
   import bool_eval_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_FUNC = 2,
   parameter logic [N_FUNC*(1<<N_IN)-1:0] TT_INIT = {F2_TT, F1_TT},
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_IN-1:0]               in_vars,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_FUNC-1:0]             out_f,
   output logic [N_IN-1:0]               out_vars,
   input  logic                          cfg_we,
   input  logic [CFG_SEL_W(N_FUNC)-1:0]  cfg_sel,
   input  logic [DEPTH_OF(N_IN)-1:0]     cfg_table,
   output logic [CNT_W-1:0]              eval_cnt
);

   localparam int DEPTH = DEPTH_OF(N_IN);
   localparam int SEL_W = CFG_SEL_W(N_FUNC);

   logic                             s1_in_rdy, s1_v, s2_in_rdy;
   logic [N_IN-1:0]                  s1_vars;
   logic [N_FUNC-1:0]                look;
   logic [N_FUNC-1:0][DEPTH-1:0]     tbl;
   logic [N_FUNC+N_IN-1:0]           s2_data;

   // Table bank: a write lands at the edge, so a lookup registered at that
   // same edge still sees the old contents.
   for (genvar f = 0; f < N_FUNC; f++) begin : g_func
      always_ff @(posedge clk) begin
         if (rst)
            tbl[f] <= TT_INIT[f*DEPTH +: DEPTH];
         else if (cfg_we && cfg_sel == SEL_W'(f))
            tbl[f] <= cfg_table;
      end
      assign look[f] = tbl[f][s1_vars];
   end

   bool_eval_stage #(.W(N_IN)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (s1_in_rdy),
      .in_data   (in_vars),
      .out_valid (s1_v),
      .out_ready (s2_in_rdy),
      .out_data  (s1_vars)
   );

   bool_eval_stage #(.W(N_FUNC+N_IN)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_v),
      .in_ready  (s2_in_rdy),
      .in_data   ({look, s1_vars}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign {out_f, out_vars} = s2_data;
   assign in_ready          = s1_in_rdy & ~rst;

   always_ff @(posedge clk) begin
      if (rst)
         eval_cnt <= '0;
      else if (out_valid && out_ready && eval_cnt != '1)
         eval_cnt <= eval_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_bool_func_eval.sv
module tb_bool_func_eval;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: defaults (N_IN=4, N_FUNC=2, CNT_W=16)
   logic        rst, in_valid, in_ready, out_valid, out_ready, cfg_we;
   logic [3:0]  in_vars, out_vars;
   logic [1:0]  out_f;
   logic [0:0]  cfg_sel;
   logic [15:0] cfg_table, eval_cnt;

   // second instance: N_FUNC=3 (2-bit select, sel=3 invalid), CNT_W=2
   logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cfg_we;
   logic [3:0]  b_in_vars, b_out_vars;
   logic [2:0]  b_out_f;
   logic [1:0]  b_cfg_sel, b_eval_cnt;
   logic [15:0] b_cfg_table;

   localparam logic [15:0] T0 = 16'h35A5, T1 = 16'hEEE2, T2 = 16'hC3A1;

   bool_func_eval #(.N_IN(4), .N_FUNC(2), .TT_INIT({T1, T0}), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_vars(in_vars), .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_vars(out_vars), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_table(cfg_table), .eval_cnt(eval_cnt));

   bool_func_eval #(.N_IN(4), .N_FUNC(3), .TT_INIT({T2, T1, T0}), .CNT_W(2)) dut2 (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_vars(b_in_vars), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_f(b_out_f), .out_vars(b_out_vars), .cfg_we(b_cfg_we), .cfg_sel(b_cfg_sel),
      .cfg_table(b_cfg_table), .eval_cnt(b_eval_cnt));

   int checks = 0, failures = 0;
   bit chk_f = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Reference model for the main instance: a FIFO of accepted samples, the
   // current truth tables, and a saturating handshake count. Checked at every
   // falling edge, where this cycle's handshakes are already settled.
   initial begin : model
      logic [15:0] mtbl [2];
      logic [3:0]  q [$];
      logic [3:0]  v;
      int          mcnt;
      bit          p_v, p_r, p_rst;
      logic [1:0]  p_f;
      logic [3:0]  p_vars;
      mtbl[0] = T0; mtbl[1] = T1; mcnt = 0;
      p_rst = 1'b1; p_v = 1'b0; p_r = 1'b0; p_f = '0; p_vars = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (p_rst) chk("reset_outputs", {out_valid, out_f, out_vars}, '0);
         if (!p_rst && p_v && !p_r)
            chk("hold_stable", {out_valid, out_f, out_vars}, {1'b1, p_f, p_vars});
         if (rst) chk("in_ready_in_reset", in_ready, 0);
         chk("eval_cnt", eval_cnt, mcnt);
         if (rst) begin
            q.delete(); mcnt = 0; mtbl[0] = T0; mtbl[1] = T1;
         end else begin
            if (out_valid) begin
               if (q.size() == 0) chk("stale_out_valid", out_valid, 0);
               else if (out_ready) begin
                  v = q.pop_front();
                  chk("out_vars", out_vars, v);
                  if (chk_f) chk("out_f", out_f, {mtbl[1][v], mtbl[0][v]});
                  if (mcnt < 65535) mcnt++;
               end
            end
            if (in_valid && in_ready) q.push_back(in_vars);
            if (cfg_we) mtbl[cfg_sel] = cfg_table;
         end
         p_v = out_valid; p_r = out_ready; p_rst = rst; p_f = out_f; p_vars = out_vars;
      end
   end

   // One sample through an idle pipe: checks acceptance, 2-cycle latency and value.
   task automatic send_one(input logic [3:0] v, input logic [1:0] ef, input string nm);
      int lat;
      in_vars = v; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
      end
      chk({nm, "_latency"}, lat, 2);
      chk({nm, "_out_f"}, out_f, ef);
      chk({nm, "_out_vars"}, out_vars, v);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1; in_valid = 0; in_vars = 0; out_ready = 0; cfg_we = 0; cfg_sel = 0; cfg_table = 0;
      b_rst = 1; b_in_valid = 0; b_in_vars = 0; b_out_ready = 1; b_cfg_we = 0; b_cfg_sel = 0;
      b_cfg_table = 0;
      step(); step();
      rst = 0; b_rst = 0;

      // T1: defaults, literal points then a full streaming sweep
      send_one(4'd5, 2'b11, "t1_v5");
      send_one(4'd3, 2'b00, "t1_v3");
      out_ready = 1;
      for (int c = 0; c < 16; c++) begin
         in_valid = 1; in_vars = 4'(c); step();
      end
      in_valid = 0;
      repeat (3) step();

      // T2: backpressure
      rst = 1; step(); rst = 0;
      out_ready = 0; in_valid = 1; in_vars = 1;
      @(negedge clk); chk("t2_rdy_c0", in_ready, 1); step();
      in_vars = 2;
      @(negedge clk); chk("t2_rdy_c1", in_ready, 1); step();
      in_vars = 3;
      @(negedge clk); chk("t2_rdy_c2", in_ready, 0);
      chk("t2_hold_c2", {out_valid, out_vars}, {1'b1, 4'd1}); step();
      @(negedge clk); chk("t2_rdy_c3", in_ready, 0);
      chk("t2_hold_c3", {out_valid, out_vars}, {1'b1, 4'd1}); step();
      out_ready = 1;
      @(negedge clk); chk("t2_rdy_c4", in_ready, 1);
      chk("t2_out1", {out_valid, out_vars}, {1'b1, 4'd1}); step();
      in_valid = 0;
      @(negedge clk); chk("t2_out2", {out_valid, out_vars}, {1'b1, 4'd2}); step();
      @(negedge clk); chk("t2_out3", {out_valid, out_vars}, {1'b1, 4'd3}); step();
      @(negedge clk); chk("t2_drained", out_valid, 0); chk("t2_cnt", eval_cnt, 3);
      step();

      // T3: table write while S1 holds vars=1
      chk_f = 0;
      in_valid = 1; in_vars = 1; out_ready = 1; step();
      cfg_we = 1; cfg_sel = 0; cfg_table = 16'hFFFF; step();
      cfg_we = 0; in_valid = 0;
      @(negedge clk); chk("t3_old_table", {out_valid, out_vars, out_f}, {1'b1, 4'd1, 2'b10}); step();
      @(negedge clk); chk("t3_new_table", {out_valid, out_vars, out_f}, {1'b1, 4'd1, 2'b11}); step();
      step();
      chk_f = 1;
      send_one(4'd1, 2'b11, "t3_after");

      // T5: reset with two samples in flight
      in_valid = 1; in_vars = 6; step();
      in_vars = 9; step();
      in_valid = 0; out_ready = 0; rst = 1; step();
      rst = 0; out_ready = 1;
      @(negedge clk); chk("t5_valid_after_rst", out_valid, 0); chk("t5_cnt", eval_cnt, 0);
      for (int c = 0; c < 4; c++) begin
         step(); @(negedge clk); chk("t5_no_stale", out_valid, 0);
      end
      step();
      send_one(4'd1, 2'b10, "t5_restored");

      // T4: invalid select on the 3-function instance leaves all tables intact
      b_cfg_we = 1; b_cfg_sel = 2'd3; b_cfg_table = 16'h0000; step();
      b_cfg_we = 0;
      for (int c = 0; c < 18; c++) begin
         logic [3:0] e;
         b_in_valid = (c < 16); b_in_vars = 4'(c);
         @(negedge clk);
         if (c >= 2) begin
            e = 4'(c - 2);
            chk("t4_sweep", {b_out_valid, b_out_vars, b_out_f}, {1'b1, e, T2[e], T1[e], T0[e]});
         end
         step();
      end
      b_in_valid = 0;

      // T6: 2-bit counter saturation
      b_rst = 1; step(); b_rst = 0;
      for (int c = 0; c < 8; c++) begin
         b_in_valid = (c < 5); b_in_vars = 4'(c);
         @(negedge clk);
         if (c >= 3) chk("t6_eval_cnt", b_eval_cnt, (c - 2 > 3) ? 3 : c - 2);
         step();
      end
      b_in_valid = 0;

      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
